regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: two-requester writeback arbiter with a register-clear sweep
module regfile_wb_arbiter #(
    parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000,
    parameter logic        PRIO_RESET  = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [4:0]  req0_dest,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_dest,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        reg_write_en,
    output logic [4:0]  reg_write_dest,
    output logic [31:0] reg_write_data
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        we_q, we_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] data_q, data_d;
    logic        done_q, done_d;
    logic        open, g0, g1;
    assign open = reset && state_q == IDLE && !clear_start;
    assign g0 = open && req0_valid && (!req1_valid || !prio_q);
    assign g1 = open && req1_valid && (!req0_valid || prio_q);
    assign req0_ready = g0;
    assign req1_ready = g1;
    assign clear_busy = state_q == CLEAR;
    assign clear_done = done_q;
    assign reg_write_en = we_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    // Next state: sweep writes take precedence; otherwise accept the granted request
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        prio_d = prio_q;
        we_d = 1'b0;
        dest_d = dest_q;
        data_d = data_q;
        done_d = 1'b0;
        if (state_q == CLEAR) begin
            we_d = 1'b1;
            dest_d = cnt_q;
            data_d = CLEAR_VALUE;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                state_d = IDLE;
                done_d = 1'b1;
            end
        end else if (clear_start) begin
            state_d = CLEAR;
            cnt_d = 5'd1;
        end else if (g0 || g1) begin
            dest_d = g1 ? req1_dest : req0_dest;
            data_d = g1 ? req1_data : req0_data;
            we_d = dest_d != 5'd0;
            prio_d = g0;
        end
    end
    // State and write-port registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= 5'd0;
            prio_q <= PRIO_RESET;
            we_q <= 1'b0;
            dest_q <= 5'd0;
            data_q <= 32'd0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            prio_q <= prio_d;
            we_q <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vectors, clear/reset sequences and a random run against a queue model
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        v0, v1, cs;
    logic [4:0]  d0, d1;
    logic [31:0] x0, x1;
    logic        r0, r1, busy, done, en;
    logic [4:0]  dest;
    logic [31:0] data;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(v0), .req0_dest(d0), .req0_data(x0), .req0_ready(r0),
        .req1_valid(v1), .req1_dest(d1), .req1_data(x1), .req1_ready(r1),
        .clear_start(cs), .clear_busy(busy), .clear_done(done),
        .reg_write_en(en), .reg_write_dest(dest), .reg_write_data(data)
    );

    typedef struct {
        logic v0, v1;
        logic [4:0] d0, d1;
        logic [31:0] x0, x1;
        logic r0, r1, en;
        logic [4:0] dest;
        logic [31:0] data;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        v0 = 1'b0; v1 = 1'b0; cs = 1'b0;
        d0 = 5'd0; d1 = 5'd0; x0 = 32'd0; x1 = 32'd0;
    endtask

    int q[$];
    logic mp, m_en, m_done, e0, e1, found;
    logic [4:0] m_dest;
    logic [31:0] m_data;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 5'd3, 5'd7, 32'h33, 32'h77, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
        tbl[1] = '{1'b1, 1'b1, 5'd3, 5'd7, 32'h33, 32'h77, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77};
        tbl[2] = '{1'b1, 1'b1, 5'd3, 5'd7, 32'h33, 32'h77, 1'b1, 1'b0, 1'b1, 5'd3, 32'h33};
        tbl[3] = '{1'b1, 1'b1, 5'd3, 5'd7, 32'h33, 32'h77, 1'b0, 1'b1, 1'b1, 5'd7, 32'h77};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h77};
        tbl[5] = '{1'b1, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        tbl[6] = '{1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        tbl[7] = '{1'b0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1};
        reset = 1'b0;
        idle_inputs();
        v0 = 1'b1; v1 = 1'b1; d0 = 5'd4; d1 = 5'd6;
        #2;
        chk("rst_r0", 32'(r0), 32'd0);
        chk("rst_r1", 32'(r1), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_dest", 32'(dest), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        idle_inputs();
        @(posedge clk); @(posedge clk); #1 reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v0 = tbl[i].v0; v1 = tbl[i].v1; d0 = tbl[i].d0; d1 = tbl[i].d1;
            x0 = tbl[i].x0; x1 = tbl[i].x1;
            #1;
            chk($sformatf("vec%0d_r0", i), 32'(r0), 32'(tbl[i].r0));
            chk($sformatf("vec%0d_r1", i), 32'(r1), 32'(tbl[i].r1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_en", i), 32'(en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_dest", i), 32'(dest), 32'(tbl[i].dest));
            chk($sformatf("vec%0d_data", i), data, tbl[i].data);
        end
        idle_inputs();
        v0 = 1'b1; d0 = 5'd9; x0 = 32'h55; cs = 1'b1;
        #1;
        chk("cs_r0", 32'(r0), 32'd0);
        @(posedge clk); #1 cs = 1'b0;
        chk("cs_en", 32'(en), 32'd0);
        chk("cs_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 31; i++) begin
            chk("clr_r0", 32'(r0), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("clr%0d_en", i), 32'(en), 32'd1);
            chk($sformatf("clr%0d_dest", i), 32'(dest), 32'(i));
            chk($sformatf("clr%0d_data", i), data, 32'd0);
            chk($sformatf("clr%0d_done", i), 32'(done), 32'(i == 31));
            chk($sformatf("clr%0d_busy", i), 32'(busy), 32'(i != 31));
        end
        chk("post_clr_r0", 32'(r0), 32'd1);
        @(posedge clk); #1;
        chk("post_clr_en", 32'(en), 32'd1);
        chk("post_clr_dest", 32'(dest), 32'd9);
        chk("post_clr_data", data, 32'h55);
        chk("post_clr_done", 32'(done), 32'd0);
        idle_inputs();
        cs = 1'b1;
        @(posedge clk); #1 cs = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (en && dest == 5'd10) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("sweep_reached_10", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_dest", 32'(dest), 32'd0);
        chk("abort_data", data, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        v0 = 1'b1;
        #1;
        chk("abort_r0", 32'(r0), 32'd0);
        v0 = 1'b0;
        #2 reset = 1'b1;
        for (int n = 0; n < 34; n++) begin
            @(posedge clk); #1;
            chk("after_abort_en", 32'(en), 32'd0);
            chk("after_abort_busy", 32'(busy), 32'd0);
        end
        v0 = 1'b1; v1 = 1'b1; d0 = 5'd2; d1 = 5'd4;
        #1;
        chk("prio_reset_r0", 32'(r0), 32'd1);
        chk("prio_reset_r1", 32'(r1), 32'd0);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        q = {};
        mp = 1'b0; m_en = 1'b0; m_done = 1'b0; m_dest = 5'd0; m_data = 32'd0;
        for (int n = 0; n < 800; n++) begin
            v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
            d0 = 5'($urandom_range(0, 31)); d1 = 5'($urandom_range(0, 31));
            x0 = $urandom; x1 = $urandom;
            cs = ($urandom_range(0, 39) == 0);
            #1;
            e0 = 1'b0; e1 = 1'b0;
            if (q.size() == 0 && !cs && (v0 || v1)) begin
                if (v0 && v1) begin e0 = !mp; e1 = mp; end
                else begin e0 = v0; e1 = v1; end
            end
            chk("rnd_r0", 32'(r0), 32'(e0));
            chk("rnd_r1", 32'(r1), 32'(e1));
            @(posedge clk);
            m_done = 1'b0;
            if (q.size() > 0) begin
                m_dest = 5'(q.pop_front());
                m_en = 1'b1;
                m_data = 32'h0;
                m_done = q.size() == 0;
            end else if (cs) begin
                for (int k = 1; k <= 31; k++) q.push_back(k);
                m_en = 1'b0;
            end else if (e0 || e1) begin
                m_dest = e1 ? d1 : d0;
                m_data = e1 ? x1 : x0;
                m_en = m_dest != 5'd0;
                mp = e0;
            end else m_en = 1'b0;
            #1;
            chk("rnd_en", 32'(en), 32'(m_en));
            chk("rnd_dest", 32'(dest), 32'(m_dest));
            chk("rnd_data", data, m_data);
            chk("rnd_busy", 32'(busy), 32'(q.size() > 0));
            chk("rnd_done", 32'(done), 32'(m_done));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
